// File: rtl/uart_frame_controller.sv
// Frame controller between UART_RX and UART_TX: hunts for HEADER, checks LEN/payload/XOR
// checksum, streams payload bytes to the NN loader and answers each frame with ACK or NAK.
module uart_frame_controller #(
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] HEADER   = 8'hAA,
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15,
  parameter int         TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       rx_en,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_done,
  output logic [7:0] pl_data,
  output logic [7:0] pl_index,
  output logic       pl_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int             TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic            ack_s;
  logic            in_frame_s;
  logic            timeout_s;
  logic [7:0]      len_r;
  logic [7:0]      count_r;
  logic [7:0]      chk_r;
  logic [TO_W-1:0] to_cnt_r;

  assign in_frame_s = (state_r == S_LEN) || (state_r == S_PAYLOAD) || (state_r == S_CHK);
  assign timeout_s  = in_frame_s && !rx_done && (to_cnt_r == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; ack_s selects the reply whenever the next state is SEND
  always_comb begin
    next_state_s = state_r;
    ack_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rx_done && (rx_data == HEADER)) next_state_s = S_LEN;
        else                                next_state_s = S_IDLE;
      end
      S_LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0)            next_state_s = S_CHK;
          else if (rx_data > MAX_LEN_B)   next_state_s = S_SEND;
          else                            next_state_s = S_PAYLOAD;
        end else if (timeout_s) begin
          next_state_s = S_SEND;
        end else begin
          next_state_s = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (rx_done) begin
          if (count_r == (len_r - 8'd1)) next_state_s = S_CHK;
          else                           next_state_s = S_PAYLOAD;
        end else if (timeout_s) begin
          next_state_s = S_SEND;
        end else begin
          next_state_s = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          next_state_s = S_SEND;
          ack_s        = (rx_data == chk_r);
        end else if (timeout_s) begin
          next_state_s = S_SEND;
        end else begin
          next_state_s = S_CHK;
        end
      end
      S_SEND:    next_state_s = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) next_state_s = S_IDLE;
        else         next_state_s = S_WAIT_TX;
      end
      default:   next_state_s = S_IDLE;
    endcase
  end

  // Frame datapath and registered outputs, all timed from next_state_s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r     <= 8'd0;
      count_r   <= 8'd0;
      chk_r     <= 8'd0;
      to_cnt_r  <= {TO_W{1'b0}};
      rx_en     <= 1'b1;
      tx_en     <= 1'b0;
      tx_data   <= 8'd0;
      pl_data   <= 8'd0;
      pl_index  <= 8'd0;
      pl_valid  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pl_valid  <= 1'b0;
      tx_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rx_en     <= (next_state_s != S_SEND) && (next_state_s != S_WAIT_TX);
      busy      <= (next_state_s != S_IDLE);

      if (in_frame_s && !rx_done) to_cnt_r <= to_cnt_r + TO_ONE;
      else                        to_cnt_r <= {TO_W{1'b0}};

      case (state_r)
        S_LEN: begin
          if (rx_done) begin
            len_r   <= rx_data;
            chk_r   <= rx_data;
            count_r <= 8'd0;
          end
        end
        S_PAYLOAD: begin
          if (rx_done) begin
            pl_valid <= 1'b1;
            pl_data  <= rx_data;
            pl_index <= count_r;
            chk_r    <= chk_update(chk_r, rx_data);
            count_r  <= count_r + 8'd1;
          end
        end
        default: ;
      endcase

      // Only frame states can enter SEND, so this fires once per frame
      if (next_state_s == S_SEND) begin
        tx_en     <= 1'b1;
        tx_data   <= ack_s ? ACK_BYTE : NAK_BYTE;
        frame_ok  <= ack_s;
        frame_err <= !ack_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_controller.sv
// Directed bench for uart_frame_controller: good/bad/empty/oversize/timeout/max-length
// frames plus noise and mid-frame reset, with hand-computed expectations.
module tb_uart_frame_controller;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_en;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_done;
  logic [7:0] pl_data;
  logic [7:0] pl_index;
  logic       pl_valid;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [15:0] pl_q[$];
  int tx_cnt = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_controller #(.MAX_LEN(16), .HEADER(8'hAA), .ACK_BYTE(8'h06),
                          .NAK_BYTE(8'h15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_en(rx_en),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done), .pl_data(pl_data),
    .pl_index(pl_index), .pl_valid(pl_valid), .frame_ok(frame_ok),
    .frame_err(frame_err), .busy(busy)
  );

  // Record payload strobes and reply pulses
  always @(negedge clk) begin
    if (pl_valid) pl_q.push_back({pl_index, pl_data});
    if (tx_en) tx_cnt++;
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL rst_rx_en: got %b expected 1", rx_en); end
    checks++; if ({tx_en, pl_valid, frame_ok, frame_err} !== 4'b0000) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {tx_en, pl_valid, frame_ok, frame_err}); end
    checks++; if ({tx_data, pl_data, pl_index} !== 24'h000000) begin errors++; $display("FAIL rst_data: got %h expected 000000", {tx_data, pl_data, pl_index}); end
  endtask

  task automatic test_good_frame();
    logic [15:0] exp_q [3] = '{16'h0010, 16'h0120, 16'h0230};
    int ok0 = ok_cnt;
    int tx0 = tx_cnt;
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h03);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL good_tx_en: got %b expected 1", tx_en); end
    checks++; if (tx_data !== 8'h06) begin errors++; $display("FAIL good_tx_data: got %h expected 06", tx_data); end
    checks++; if ({frame_ok, frame_err} !== 2'b10) begin errors++; $display("FAIL good_ok_err: got %b expected 10", {frame_ok, frame_err}); end
    @(negedge clk);
    checks++; if ({tx_en, frame_ok, busy, rx_en} !== 4'b0010) begin errors++; $display("FAIL good_wait: got %b expected 0010", {tx_en, frame_ok, busy, rx_en}); end
    send_byte(8'hAA);
    checks++; if (tx_data !== 8'h06) begin errors++; $display("FAIL good_hold: got %h expected 06", tx_data); end
    pulse_tx_done();
    checks++; if ({busy, rx_en} !== 2'b01) begin errors++; $display("FAIL good_idle: got %b expected 01", {busy, rx_en}); end
    #1;
    checks++; if (pl_q.size() != 3) begin errors++; $display("FAIL good_pl_count: got %0d expected 3", pl_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (i >= pl_q.size() || pl_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_pl_%0d: got %h expected %h", i, (i < pl_q.size()) ? pl_q[i] : 16'hxxxx, exp_q[i]); end
    end
    checks++; if ((ok_cnt - ok0) != 1 || (tx_cnt - tx0) != 1) begin errors++; $display("FAIL good_pulses: got ok=%0d tx=%0d expected 1 1", ok_cnt - ok0, tx_cnt - tx0); end
  endtask

  task automatic test_bad_checksum();
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF);
    checks++; if ({tx_en, tx_data} !== 9'h115) begin errors++; $display("FAIL badchk_tx: got %h expected 115", {tx_en, tx_data}); end
    checks++; if ({frame_ok, frame_err} !== 2'b01) begin errors++; $display("FAIL badchk_ok_err: got %b expected 01", {frame_ok, frame_err}); end
    pulse_tx_done(); #1;
    checks++; if (pl_q.size() != 2 || pl_q[0] !== 16'h0001 || pl_q[1] !== 16'h0102) begin errors++; $display("FAIL badchk_pl: got size %0d expected 2 strobes 0001,0102", pl_q.size()); end
  endtask

  task automatic test_zero_len();
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00);
    checks++; if ({tx_en, tx_data, frame_ok} !== 10'h20D) begin errors++; $display("FAIL zero_tx: got %h expected 20d", {tx_en, tx_data, frame_ok}); end
    pulse_tx_done(); #1;
    checks++; if (pl_q.size() != 0) begin errors++; $display("FAIL zero_pl: got %0d expected 0", pl_q.size()); end
  endtask

  task automatic test_oversize();
    int tx0 = tx_cnt;
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h11);
    checks++; if ({tx_en, tx_data, frame_err} !== 10'h22B) begin errors++; $display("FAIL over_tx: got %h expected 22b", {tx_en, tx_data, frame_err}); end
    pulse_tx_done();
    send_byte(8'h01); send_byte(8'h02);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL over_idle: got %b expected 0", busy); end
    #1;
    checks++; if (pl_q.size() != 0 || (tx_cnt - tx0) != 1) begin errors++; $display("FAIL over_discard: got pl=%0d tx=%0d expected 0 1", pl_q.size(), tx_cnt - tx0); end
  endtask

  task automatic test_timeout();
    int n = 0;
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h05);
    while (tx_en !== 1'b1 && n < TO + 10) begin
      @(negedge clk); n++;
    end
    checks++; if (n != TO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); end
    checks++; if ({tx_data, frame_err, frame_ok} !== 10'h056) begin errors++; $display("FAIL timeout_nak: got %h expected 056", {tx_data, frame_err, frame_ok}); end
    pulse_tx_done();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b expected 0", busy); end
    #1;
    checks++; if (pl_q.size() != 1 || pl_q[0] !== 16'h0005) begin errors++; $display("FAIL timeout_pl: got size %0d expected 1 strobe 0005", pl_q.size()); end
  endtask

  task automatic test_max_len();
    logic [7:0] chk = 8'h10;
    logic [7:0] d;
    int bad = 0;
    pl_q.delete();
    send_byte(8'hAA); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 7 + 3);
      chk = chk ^ d;
      send_byte(d);
    end
    send_byte(chk);
    checks++; if ({tx_en, tx_data, frame_ok} !== 10'h20D) begin errors++; $display("FAIL maxlen_tx: got %h expected 20d", {tx_en, tx_data, frame_ok}); end
    pulse_tx_done(); #1;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 7 + 3);
      if (i >= pl_q.size() || pl_q[i] !== {8'(i), d}) bad++;
    end
    checks++; if (pl_q.size() != 16 || bad != 0) begin errors++; $display("FAIL maxlen_pl: got size %0d with %0d wrong expected 16 with 0", pl_q.size(), bad); end
  endtask

  task automatic test_noise_reset();
    int tx0 = tx_cnt;
    pl_q.delete();
    send_byte(8'h55);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_busy: got %b expected 0", busy); end
    send_byte(8'hAA);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noise_hdr: got %b expected 1", busy); end
    send_byte(8'h02); send_byte(8'h01);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if ({busy, rx_en, tx_en, pl_valid, frame_ok, frame_err} !== 6'b010000) begin errors++; $display("FAIL midrst_ctrl: got %b expected 010000", {busy, rx_en, tx_en, pl_valid, frame_ok, frame_err}); end
    checks++; if ({tx_data, pl_data, pl_index} !== 24'h000000) begin errors++; $display("FAIL midrst_data: got %h expected 000000", {tx_data, pl_data, pl_index}); end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if ((tx_cnt - tx0) != 0 || pl_q.size() != 1) begin errors++; $display("FAIL midrst_quiet: got tx=%0d pl=%0d expected 0 1", tx_cnt - tx0, pl_q.size()); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    checks++; if ({tx_en, tx_data, frame_ok} !== 10'h20D) begin errors++; $display("FAIL postrst_ack: got %h expected 20d", {tx_en, tx_data, frame_ok}); end
    pulse_tx_done(); #1;
    checks++; if (pl_q.size() != 2 || pl_q[1] !== 16'h007E) begin errors++; $display("FAIL postrst_pl: got size %0d expected 2 ending 007e", pl_q.size()); end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_good_frame();
    test_bad_checksum();
    test_zero_len();
    test_oversize();
    test_timeout();
    test_max_len();
    test_noise_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
